r4mdc_stage_ctrl: RTL and testbench

R4MDC_STAGE_CTRL -- requirements
Module: r4mdc_stage_ctrl

---
 rtl/r4mdc_stage_ctrl.sv | 104 ++++++++++
 tb/tb_r4mdc_stage_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/r4mdc_stage_ctrl.sv
// Radix-4 MDC stage controller: input commutator/delay-line sequencing, zero-pad
// flush completion, butterfly valid/twiddle issue and result-valid delay pipe.
module r4mdc_stage_ctrl #(
    parameter int unsigned L_LOG2   = 2,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [1:0]        comm_sel,
    output logic              dl_we,
    output logic              pad_en,
    output logic              bf_valid,
    output logic [L_LOG2-1:0] tw_k,
    output logic              out_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned CW = L_LOG2 + 2;
    localparam logic [L_LOG2-1:0] TW_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic              accept;
    logic              step;
    logic              last_path;
    logic [PIPE_LAT-1:0] v_pipe;
    logic [PIPE_LAT-1:0] last_pipe;

    // Sample-rate controls follow the current count; reset masks them immediately.
    assign in_ready  = ~rst & (state != DRAIN);
    assign accept    = in_valid & in_ready;
    assign step      = (state == DRAIN) ? ~rst : accept;
    assign cnt_inc   = cnt + CW'(1);
    assign comm_sel  = cnt[CW-1 -: 2];
    assign last_path = (comm_sel == 2'b11);
    assign dl_we     = step;
    assign pad_en    = ~rst & (state == DRAIN);
    assign busy      = ~rst & (state != IDLE);

    assign out_valid  = v_pipe[PIPE_LAT-1];
    assign frame_done = last_pipe[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bf_valid  <= 1'b0;
            tw_k      <= '0;
            v_pipe    <= '0;
            last_pipe <= '0;
        end else begin
            if (step) begin
                cnt <= cnt_inc;
            end

            // A same-cycle accept is counted before flush is considered.
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (step && (cnt_inc == '0)) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_inc == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // All four paths are aligned once the fourth quarter of the block arrives.
            bf_valid <= step & last_path;
            if (step && last_path) begin
                tw_k <= cnt[L_LOG2-1:0];
            end

            v_pipe[0]    <= bf_valid;
            last_pipe[0] <= bf_valid & (tw_k == TW_LAST);
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                v_pipe[i]    <= v_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_r4mdc_stage_ctrl.sv
// Directed bench for r4mdc_stage_ctrl at L_LOG2=2, PIPE_LAT=1: reset, full block,
// stall, flush-drain, flush on the last sample and reset during drain.
module tb_r4mdc_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [1:0] comm_sel;
    logic       dl_we;
    logic       pad_en;
    logic       bf_valid;
    logic [1:0] tw_k;
    logic       out_valid;
    logic       frame_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    r4mdc_stage_ctrl #(
        .L_LOG2  (2),
        .PIPE_LAT(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .comm_sel  (comm_sel),
        .dl_we     (dl_we),
        .pad_en    (pad_en),
        .bf_valid  (bf_valid),
        .tw_k      (tw_k),
        .out_valid (out_valid),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check every output, advance.
    task automatic cycle(input int iv, input int fl, input int rs, input string tag, input int idx,
                         input int ir, input int we, input int cs, input int pad,
                         input int bf, input int tw, input int ov, input int fd, input int bz);
        string t;
        rst      = 1'(rs);
        in_valid = 1'(iv);
        flush    = 1'(fl);
        #1;
        t = $sformatf("%s[%0d]", tag, idx);
        chk({t, ".in_ready"},   32'(in_ready),   32'(ir));
        chk({t, ".dl_we"},      32'(dl_we),      32'(we));
        chk({t, ".comm_sel"},   32'(comm_sel),   32'(cs));
        chk({t, ".pad_en"},     32'(pad_en),     32'(pad));
        chk({t, ".bf_valid"},   32'(bf_valid),   32'(bf));
        if (tw >= 0) chk({t, ".tw_k"}, 32'(tw_k), 32'(tw));
        chk({t, ".out_valid"},  32'(out_valid),  32'(ov));
        chk({t, ".frame_done"}, 32'(frame_done), 32'(fd));
        chk({t, ".busy"},       32'(busy),       32'(bz));
        @(negedge clk);
    endtask

    // Cycle e of an uninterrupted 16-sample block started from IDLE.
    task automatic blk_cycle(input int e, input int fl, input string tag);
        int bf;
        bf = (e >= 13 && e <= 16) ? 1 : 0;
        cycle((e < 16) ? 1 : 0, fl, 0, tag, e,
              1, (e < 16) ? 1 : 0, (e < 16) ? e / 4 : 0, 0,
              bf, (bf != 0) ? e - 13 : -1,
              (e >= 14 && e <= 17) ? 1 : 0, (e == 17) ? 1 : 0,
              (e >= 1 && e < 16) ? 1 : 0);
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b1;
        flush    = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            cycle(1, 0, 1, "reset", i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, "release", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int e = 0; e < 20; e++) blk_cycle(e, 0, "block");

        for (int e = 0; e < 5; e++) blk_cycle(e, 0, "stall_pre");
        for (int s = 0; s < 3; s++)
            cycle(0, 0, 0, "stall", s, 1, 0, 1, 0, 0, -1, 0, 0, 1);
        for (int e = 5; e < 20; e++) blk_cycle(e, 0, "stall_post");

        for (int e = 0; e < 6; e++) blk_cycle(e, 0, "flush_pre");
        cycle(0, 1, 0, "flush_req", 0, 1, 0, 1, 0, 0, -1, 0, 0, 1);
        for (int d = 0; d < 13; d++) begin
            int bf;
            bf = (d >= 7 && d <= 10) ? 1 : 0;
            cycle(0, 0, 0, "drain", d,
                  (d < 10) ? 0 : 1, (d < 10) ? 1 : 0, (d < 10) ? (6 + d) / 4 : 0,
                  (d < 10) ? 1 : 0, bf, (bf != 0) ? d - 7 : -1,
                  (d >= 8 && d <= 11) ? 1 : 0, (d == 11) ? 1 : 0, (d < 10) ? 1 : 0);
        end

        for (int e = 0; e < 20; e++) blk_cycle(e, (e == 15) ? 1 : 0, "flush_last");

        for (int e = 0; e < 6; e++) blk_cycle(e, 0, "rstd_pre");
        cycle(0, 1, 0, "rstd_flush", 0, 1, 0, 1, 0, 0, -1, 0, 0, 1);
        for (int d = 0; d < 2; d++)
            cycle(0, 0, 0, "rstd_drain", d, 0, 1, 1 + d / 2, 1, 0, -1, 0, 0, 1);
        cycle(0, 0, 1, "rstd_assert", 0, 0, 0, 2, 0, 0, -1, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cycle(0, 0, 0, "rstd_after", i, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
